// File: rtl/id_issue_ctrl_pkg.sv
// Shared definitions for the ID issue stage.
// Holds the decoded-bundle field offsets, the opcode constants used by
// decode, the x0 index, and the per-entry metadata and scoreboard types.
package id_issue_ctrl_pkg;

    localparam logic [4:0] X0 = 5'd0;

    // Major opcodes shared with the decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Field offsets inside the opaque decoded bundle
    localparam int BF_PC_LSB     = 0;
    localparam int BF_IMM_LSB    = 32;
    localparam int BF_ALU_SEL_LSB = 64;
    localparam int BF_WB_SEL_LSB = 72;

    // Hazard-relevant fields that travel with each bundle
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
        logic [4:0] rd;
        logic       is_load;
        logic       halt;
    } meta_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
    } sb_ent_t;

    // True when the instruction actually reads register r (x0 never counts)
    function automatic logic reads_reg(meta_t m, logic [4:0] r);
        return (r != X0) && ((m.use_rs1 && m.rs1 == r) || (m.use_rs2 && m.rs2 == r));
    endfunction

endpackage

// File: rtl/id_issue_ctrl_if.sv
// Decode -> issue -> EX handshake bundle.
// slave  : the issue stage (consumes decoder inputs, drives EX side)
// master : the environment (decoder + EX + redirect source)
interface id_issue_ctrl_if #(
    parameter int BUNDLE_W = 96,
    parameter int CNT_W    = 16
) ();
    logic                in_valid;
    logic                in_ready;
    logic [BUNDLE_W-1:0] in_bundle;
    logic [4:0]          in_rs1;
    logic [4:0]          in_rs2;
    logic                in_use_rs1;
    logic                in_use_rs2;
    logic [4:0]          in_rd;
    logic                in_is_load;
    logic                in_halt;
    logic                out_valid;
    logic                out_ready;
    logic [BUNDLE_W-1:0] out_bundle;
    logic                out_halt;
    logic                flush;
    logic [CNT_W-1:0]    stall_cnt;

    modport slave (
        input  in_valid, in_bundle, in_rs1, in_rs2, in_use_rs1, in_use_rs2,
               in_rd, in_is_load, in_halt, out_ready, flush,
        output in_ready, out_valid, out_bundle, out_halt, stall_cnt
    );

    modport master (
        output in_valid, in_bundle, in_rs1, in_rs2, in_use_rs1, in_use_rs2,
               in_rd, in_is_load, in_halt, out_ready, flush,
        input  in_ready, out_valid, out_bundle, out_halt, stall_cnt
    );
endinterface

// File: rtl/id_issue_ctrl_fifo.sv
// issue_fifo: small synchronous FIFO with registered-pointer full/empty.
// Ports: clk/rst (sync, active high), i_clear (drop all entries),
// i_push/i_wdata, i_pop/o_rdata (head, combinational read),
// o_full, o_empty, o_count.
module issue_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Wrap bit differs and index matches -> full
    assign o_empty  = (r_wptr == r_rptr);
    assign o_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_count  = r_wptr - r_rptr;
    assign o_rdata  = r_mem[r_rptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
endmodule

// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: issue stage between decode and the ID/EX register.
// Buffers decoded bundles, inserts bubbles for load-use hazards against
// loads still inside the LOAD_LAT window, squashes on flush and latches halt.
// Ports: clk, rst (sync, active high), bus (id_issue_ctrl_if.slave):
//   in_*      decoder side valid/ready + bundle and hazard metadata
//   out_*     ID/EX register valid/ready + bundle, sticky out_halt
//   flush     redirect from EX, stall_cnt saturating bubble counter
module id_issue_ctrl
    import id_issue_ctrl_pkg::*;
#(
    parameter int BUNDLE_W = 96,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    id_issue_ctrl_if.slave bus
);
    localparam int ENT_W = BUNDLE_W + $bits(meta_t);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FIFO_MAX = CW'(DEPTH);

    logic                r_out_valid;
    logic [BUNDLE_W-1:0] r_out_bundle;
    logic                r_halt;
    logic [CNT_W-1:0]    r_stall;
    sb_ent_t [LOAD_LAT-1:0] r_sb;   // [0] = ID/EX occupant, older loads above

    meta_t               w_in_meta;
    meta_t               w_head;
    logic [BUNDLE_W-1:0] w_head_bundle;
    logic [ENT_W-1:0]    w_wdata;
    logic [ENT_W-1:0]    w_rdata;
    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    logic                w_in_ready;
    logic                w_push;
    logic                w_adv;
    logic                w_hazard;
    logic                w_issue;

    assign w_in_meta = '{rs1: bus.in_rs1, rs2: bus.in_rs2,
                         use_rs1: bus.in_use_rs1, use_rs2: bus.in_use_rs2,
                         rd: bus.in_rd, is_load: bus.in_is_load, halt: bus.in_halt};
    assign w_wdata   = {bus.in_bundle, w_in_meta};
    assign {w_head_bundle, w_head} = w_rdata;

    // in_ready reflects the registered full flag; a same-cycle pop does not
    // open a slot for the push. Pushes during a flush are discarded.
    assign w_in_ready = !w_full && !r_halt;
    assign w_push     = bus.in_valid && w_in_ready && !bus.flush;

    issue_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (bus.flush),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_issue),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_hazard = 1'b0;
        if (!w_empty) begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                if (r_sb[i].v && reads_reg(w_head, r_sb[i].rd)) w_hazard = 1'b1;
            end
        end
    end

    assign w_adv   = bus.out_ready || !r_out_valid;
    // Nothing behind a halting bundle is ever issued
    assign w_issue = w_adv && !w_empty && !w_hazard && !bus.flush && !r_halt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_bundle <= '0;
            r_sb         <= '0;
            r_halt       <= 1'b0;
            r_stall      <= '0;
        end else begin
            if (w_adv) begin
                r_out_valid <= w_issue;
                if (w_issue) r_out_bundle <= w_head_bundle;
                for (int i = LOAD_LAT - 1; i >= 1; i--) r_sb[i] <= r_sb[i-1];
                r_sb[0] <= '{v: w_issue && w_head.is_load && (w_head.rd != X0),
                             rd: w_head.rd};
                if (w_hazard && (r_stall != {CNT_W{1'b1}})) r_stall <= r_stall + CNT_W'(1);
            end
            // Flush kills the ID/EX occupant; older in-flight loads keep aging
            if (bus.flush) begin
                r_out_valid <= 1'b0;
                r_sb[0].v   <= 1'b0;
            end
            if (w_issue && w_head.halt) r_halt <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (w_count <= FIFO_MAX);
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_bundle = r_out_bundle;
    assign bus.out_halt   = r_halt;
    assign bus.stall_cnt  = r_stall;
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Testbench for id_issue_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=2)
// share the same stimulus; directed scenarios plus a randomized run
// checked against a queue-level behavioural model.
module tb_id_issue_ctrl;
    localparam int BW = 96;
    localparam int CW = 16;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          t_valid, t_ready, t_flush;
    logic [BW-1:0] t_bundle;
    logic [4:0]    t_rs1, t_rs2, t_rd;
    logic          t_u1, t_u2, t_ld, t_halt;

    id_issue_ctrl_if #(.BUNDLE_W(BW), .CNT_W(CW)) b1 ();
    id_issue_ctrl_if #(.BUNDLE_W(BW), .CNT_W(CW)) b2 ();

    assign b1.in_valid = t_valid;   assign b2.in_valid = t_valid;
    assign b1.in_bundle = t_bundle; assign b2.in_bundle = t_bundle;
    assign b1.in_rs1 = t_rs1;       assign b2.in_rs1 = t_rs1;
    assign b1.in_rs2 = t_rs2;       assign b2.in_rs2 = t_rs2;
    assign b1.in_use_rs1 = t_u1;    assign b2.in_use_rs1 = t_u1;
    assign b1.in_use_rs2 = t_u2;    assign b2.in_use_rs2 = t_u2;
    assign b1.in_rd = t_rd;         assign b2.in_rd = t_rd;
    assign b1.in_is_load = t_ld;    assign b2.in_is_load = t_ld;
    assign b1.in_halt = t_halt;     assign b2.in_halt = t_halt;
    assign b1.out_ready = t_ready;  assign b2.out_ready = t_ready;
    assign b1.flush = t_flush;      assign b2.flush = t_flush;

    id_issue_ctrl #(.BUNDLE_W(BW), .DEPTH(DEPTH), .LOAD_LAT(1), .CNT_W(CW)) u1 (
        .clk(clk), .rst(rst), .bus(b1));
    id_issue_ctrl #(.BUNDLE_W(BW), .DEPTH(DEPTH), .LOAD_LAT(2), .CNT_W(CW)) u2 (
        .clk(clk), .rst(rst), .bus(b2));

    // Observed outputs, index k = instance (k+1 = its LOAD_LAT)
    logic          ov [2];
    logic          ir [2];
    logic          oh [2];
    logic [BW-1:0] ob [2];
    logic [CW-1:0] sc [2];
    assign ov[0] = b1.out_valid;  assign ov[1] = b2.out_valid;
    assign ir[0] = b1.in_ready;   assign ir[1] = b2.in_ready;
    assign oh[0] = b1.out_halt;   assign oh[1] = b2.out_halt;
    assign ob[0] = b1.out_bundle; assign ob[1] = b2.out_bundle;
    assign sc[0] = b1.stall_cnt;  assign sc[1] = b2.stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        t_valid = 1'b0; t_flush = 1'b0; t_ready = 1'b1; t_bundle = '0;
        t_rs1 = '0; t_rs2 = '0; t_rd = '0; t_u1 = 1'b0; t_u2 = 1'b0;
        t_ld = 1'b0; t_halt = 1'b0;
    endtask

    task automatic put(input int tag, input int rs1, input int rs2, input bit u1_, input bit u2_,
                       input int rd, input bit ld, input bit hlt);
        t_valid = 1'b1; t_bundle = BW'(tag);
        t_rs1 = 5'(rs1); t_rs2 = 5'(rs2); t_rd = 5'(rd);
        t_u1 = u1_; t_u2 = u2_; t_ld = ld; t_halt = hlt;
    endtask

    task automatic next();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        next(); rst = 1'b1; idle(); next(); rst = 1'b0;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [BW-1:0] b;
        logic [4:0] rs1, rs2, rd;
        logic u1, u2, ld, h;
    } ent_t;

    ent_t          mf [2][DEPTH];
    int            mcnt [2];
    logic          m_ov [2];
    logic [BW-1:0] m_ob [2];
    logic          m_halt [2];
    int            m_stall [2];
    int            recent [2][2];   // rd of loads issued in the last slots, 0 = none

    task automatic model_clear(input int k);
        mcnt[k] = 0; m_ov[k] = 1'b0; m_ob[k] = '0; m_halt[k] = 1'b0;
        m_stall[k] = 0; recent[k][0] = 0; recent[k][1] = 0;
    endtask

    task automatic model_step(input int k, input int lat);
        ent_t h, cur;
        bit rdy, adv, haz, iss;
        if (rst) begin model_clear(k); return; end
        cur = '{b: t_bundle, rs1: t_rs1, rs2: t_rs2, rd: t_rd, u1: t_u1, u2: t_u2, ld: t_ld, h: t_halt};
        rdy = (mcnt[k] < DEPTH) && !m_halt[k];
        adv = t_ready || !m_ov[k];
        h = mf[k][0];
        haz = 1'b0;
        if (mcnt[k] > 0)
            for (int j = 0; j < lat; j++)
                if (recent[k][j] != 0 && ((h.u1 && int'(h.rs1) == recent[k][j]) ||
                                          (h.u2 && int'(h.rs2) == recent[k][j]))) haz = 1'b1;
        iss = adv && mcnt[k] > 0 && !haz && !t_flush && !m_halt[k];
        if (adv && haz && m_stall[k] < 65535) m_stall[k]++;
        if (adv) begin
            recent[k][1] = recent[k][0];
            recent[k][0] = (iss && h.ld) ? int'(h.rd) : 0;
        end
        if (t_flush) recent[k][0] = 0;
        if (iss) begin
            m_ov[k] = 1'b1; m_ob[k] = h.b;
            if (h.h) m_halt[k] = 1'b1;
            mf[k][0] = mf[k][1]; mcnt[k]--;
        end else if (adv) m_ov[k] = 1'b0;
        if (t_flush) begin
            m_ov[k] = 1'b0; mcnt[k] = 0;
        end else if (t_valid && rdy) begin
            mf[k][mcnt[k]] = cur; mcnt[k]++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        put(99, 1, 2, 1, 1, 3, 1, 0);
        repeat (3) next();
        rst = 1'b0; idle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (ov[k] !== 1'b0 || ob[k] !== '0 || oh[k] !== 1'b0 || sc[k] !== '0 || ir[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset k=%0d ov=%b ob=%0h oh=%b sc=%0d ir=%b (want 0,0,0,0,1)",
                         k, ov[k], ob[k], oh[k], sc[k], ir[k]);
            end
        end
        // Reset in the middle of traffic: nothing already buffered leaks out
        next(); put(50, 1, 2, 1, 1, 3, 0, 0);
        next(); put(51, 1, 2, 1, 1, 3, 0, 0); rst = 1'b1;
        next(); idle(); rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (ov[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_leak k=%0d c=%0d ov=%b want 0 ob=%0d", k, c, ov[k], ob[k]);
                end
            end
            next();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c < 3) put(10 + c, 1, 2, 1, 1, 7 + c, 0, 0); else idle();
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (ov[k] !== (c >= 2 && c <= 4) || (ov[k] && ob[k] !== BW'(10 + c - 2))) begin
                    n_fail++;
                    $display("FAIL back_to_back k=%0d c=%0d ov=%b ob=%0d want_ov=%b want_ob=%0d",
                             k, c, ov[k], ob[k], (c >= 2 && c <= 4), 10 + c - 2);
                end
            end
            next();
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (sc[k] !== 16'd0) begin
                n_fail++; $display("FAIL back_to_back_stall k=%0d got=%0d want=0", k, sc[k]);
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c == 0) put(1, 2, 0, 1, 0, 5, 1, 0);        // lw x5,0(x2)
            else if (c == 1) put(2, 5, 1, 1, 1, 6, 0, 0);   // add x6,x5,x1
            else idle();
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int add_c;
                bit eov;
                add_c = 3 + (k + 1);   // one bubble per cycle of load latency
                eov = (c == 2) || (c == add_c);
                n_tests++;
                if (ov[k] !== eov || (ov[k] && ob[k] !== BW'((c == 2) ? 1 : 2))) begin
                    n_fail++;
                    $display("FAIL load_use k=%0d c=%0d ov=%b ob=%0d want_ov=%b", k, c, ov[k], ob[k], eov);
                end
            end
            next();
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (sc[k] !== 16'(k + 1)) begin
                n_fail++; $display("FAIL load_use_stall k=%0d got=%0d want=%0d", k, sc[k], k + 1);
            end
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            case (c)
                0: put(1, 2, 0, 1, 0, 0, 1, 0);   // lw x0
                1: put(2, 0, 0, 1, 1, 6, 0, 0);   // add x6,x0,x0
                2: put(3, 2, 0, 1, 0, 5, 1, 0);   // lw x5
                3: put(4, 1, 5, 1, 0, 7, 0, 0);   // addi x7,x1,3 (rs2 field = 5, unused)
                default: idle();
            endcase
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (ov[k] !== (c >= 2 && c <= 5) || (ov[k] && ob[k] !== BW'(c - 1))) begin
                    n_fail++;
                    $display("FAIL no_hazard k=%0d c=%0d ov=%b ob=%0d want_ob=%0d", k, c, ov[k], ob[k], c - 1);
                end
            end
            next();
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (sc[k] !== 16'd0) begin
                n_fail++; $display("FAIL no_hazard_stall k=%0d got=%0d want=0", k, sc[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int nxt;
        int ng [2];
        int got [2][8];
        nxt = 0; ng[0] = 0; ng[1] = 0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            if (nxt < 4) put(20 + nxt, 1, 2, 1, 1, 9, 0, 0); else idle();
            t_ready = (c >= 8);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (c >= 3 && c <= 7) begin
                    n_tests++;
                    if (ir[k] !== 1'b0 || ov[k] !== 1'b1 || ob[k] !== BW'(20)) begin
                        n_fail++;
                        $display("FAIL bp_hold k=%0d c=%0d ir=%b ov=%b ob=%0d want 0,1,20", k, c, ir[k], ov[k], ob[k]);
                    end
                end
                if (c == 8) begin
                    n_tests++;
                    if (ir[k] !== 1'b0) begin
                        n_fail++; $display("FAIL bp_full_pop k=%0d in_ready=%b want 0", k, ir[k]);
                    end
                end
                if (ov[k] && t_ready && ng[k] < 8) begin
                    got[k][ng[k]] = int'(ob[k][15:0]); ng[k]++;
                end
            end
            if (t_valid && ir[0]) nxt++;
            next();
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (ng[k] != 4 || got[k][0] != 20 || got[k][1] != 21 || got[k][2] != 22 || got[k][3] != 23) begin
                n_fail++;
                $display("FAIL bp_order k=%0d count=%0d seq=%0d,%0d,%0d,%0d want 4: 20,21,22,23",
                         k, ng[k], got[k][0], got[k][1], got[k][2], got[k][3]);
            end
        end
    endtask

    task automatic test_flush();
        int tagv [18] = '{30, 31, 32, 33, 0, 0, 0, 0, 34, 35, 36, 0, 0, 0, 0, 37, 0, 0};
        int expv [18] = '{0, 0, 30, 30, 0, 0, 0, 0, 0, 0, 34, 0, 0, 0, 0, 0, 0, 37};
        do_reset();
        for (int c = 0; c < 18; c++) begin
            if (tagv[c] != 0) put(tagv[c], 1, 2, 1, 1, 4, 0, 0); else idle();
            t_flush = (c == 3 || c == 10);
            t_ready = !(c <= 3 || (c >= 8 && c <= 10));
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (ov[k] !== (expv[c] != 0) || (ov[k] && ob[k] !== BW'(expv[c]))) begin
                    n_fail++;
                    $display("FAIL flush k=%0d c=%0d ov=%b ob=%0d want_tag=%0d", k, c, ov[k], ob[k], expv[c]);
                end
                if (c == 3 || c == 4 || c == 10) begin
                    n_tests++;
                    if (ir[k] !== (c != 3)) begin
                        n_fail++;
                        $display("FAIL flush_ready k=%0d c=%0d in_ready=%b want %b", k, c, ir[k], (c != 3));
                    end
                end
            end
            next();
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c == 0) put(40, 1, 2, 1, 1, 3, 0, 1);
            else if (c == 1) put(41, 1, 2, 1, 1, 3, 0, 0);
            else if (c <= 6) put(42, 1, 2, 1, 1, 3, 0, 0);
            else idle();
            rst = (c == 7);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (c >= 2 && c <= 6) begin
                    n_tests++;
                    if (oh[k] !== 1'b1 || ir[k] !== 1'b0 || ov[k] !== (c == 2) || (c == 2 && ob[k] !== BW'(40))) begin
                        n_fail++;
                        $display("FAIL halt k=%0d c=%0d oh=%b ir=%b ov=%b ob=%0d", k, c, oh[k], ir[k], ov[k], ob[k]);
                    end
                end
                if (c == 8) begin
                    n_tests++;
                    if (oh[k] !== 1'b0 || ir[k] !== 1'b1 || ov[k] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL halt_reset k=%0d oh=%b ir=%b ov=%b want 0,1,0", k, oh[k], ir[k], ov[k]);
                    end
                end
            end
            next();
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        model_clear(0); model_clear(1);
        for (int c = 0; c < 1500; c++) begin
            rst      = ($urandom_range(0, 99) < 2);
            t_valid  = ($urandom_range(0, 9) < 7);
            t_ready  = ($urandom_range(0, 9) < 7);
            t_flush  = ($urandom_range(0, 99) < 5);
            t_bundle = {$urandom(), $urandom(), $urandom()};
            t_rs1    = 5'($urandom_range(0, 3));
            t_rs2    = 5'($urandom_range(0, 3));
            t_rd     = 5'($urandom_range(0, 3));
            t_u1     = 1'($urandom_range(0, 1));
            t_u2     = 1'($urandom_range(0, 1));
            t_ld     = ($urandom_range(0, 9) < 4);
            t_halt   = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (ov[k] !== m_ov[k] || (m_ov[k] && ob[k] !== m_ob[k]) || oh[k] !== m_halt[k] ||
                    ir[k] !== ((mcnt[k] < DEPTH) && !m_halt[k]) || sc[k] !== 16'(m_stall[k])) begin
                    n_fail++;
                    $display("FAIL random k=%0d c=%0d ov=%b/%b ob=%0h/%0h oh=%b/%b ir=%b sc=%0d/%0d",
                             k, c, ov[k], m_ov[k], ob[k], m_ob[k], oh[k], m_halt[k], ir[k], sc[k], m_stall[k]);
                end
            end
            for (int k = 0; k < 2; k++) model_step(k, k + 1);
            next();
        end
        rst = 1'b0; idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_no_hazard();
        test_backpressure();
        test_flush();
        test_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
